// File: rtl/us_pkg.sv
// Shared types and defaults for the ultrasonic distance filter.
package us_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CLEAR = 2'd1,
    SET   = 2'd2
  } obst_state_t;

  localparam int FRONT_END_CYCLE  = 600600;
  localparam int NO_ECHO_MM_DEF   = 4000;
  localparam int NEAR_MM_DEF      = 70;
  localparam int FAR_MM_DEF       = 90;

endpackage

// File: rtl/us_moving_avg.sv
// Power-of-two moving average over strobed samples: ring, running sum, fill count.
module us_moving_avg
  import us_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic [15:0] sample,
  input  logic        sample_strobe,
  output logic [15:0] distance_avg,
  output logic        avg_valid
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 16 + AVG_LOG2;

  logic [15:0]         ring_reg [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr_reg;
  logic [AVG_LOG2:0]   fill_reg;
  logic [SW-1:0]       sum_reg;
  logic                upd_reg;
  logic [15:0]         distance_avg_reg;
  logic                avg_valid_reg;

  logic                full;
  logic [15:0]         oldest;
  logic [SW-1:0]       sum_next;

  assign full     = (fill_reg == (AVG_LOG2 + 1)'(DEPTH));
  // Empty slots contribute nothing while the window is still filling.
  assign oldest   = full ? ring_reg[wr_ptr_reg] : 16'd0;
  assign sum_next = sum_reg + SW'(sample) - SW'(oldest);

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ring_reg[i] <= 16'd0;
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      sum_reg    <= '0;
      upd_reg    <= 1'b0;
    end else begin
      upd_reg <= sample_strobe;
      if (sample_strobe) begin
        ring_reg[wr_ptr_reg] <= sample;
        wr_ptr_reg           <= wr_ptr_reg + 1'b1;
        sum_reg              <= sum_next;
        if (!full) fill_reg <= fill_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      distance_avg_reg <= 16'd0;
      avg_valid_reg    <= 1'b0;
    end else if (upd_reg) begin
      distance_avg_reg <= 16'(sum_reg >> AVG_LOG2);
      avg_valid_reg    <= avg_valid_reg | full;
    end
  end

  assign distance_avg = distance_avg_reg;
  assign avg_valid    = avg_valid_reg;

endmodule

// File: rtl/us_distance_filter.sv
// Periodic sampler, moving-average smoother and hysteretic, debounced obstacle detector.
module us_distance_filter
  import us_pkg::*;
#(
  parameter int SAMPLE_PERIOD = FRONT_END_CYCLE,
  parameter int AVG_LOG2      = 2,
  parameter int NO_ECHO_MM    = NO_ECHO_MM_DEF,
  parameter int NEAR_MM       = NEAR_MM_DEF,
  parameter int FAR_MM        = FAR_MM_DEF,
  parameter int CONFIRM       = 3
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic [15:0] distance_in,
  output logic        sample_strobe,
  output logic [15:0] distance_avg,
  output logic        avg_valid,
  output logic        obstacle
);

  localparam int CW   = $clog2(SAMPLE_PERIOD);
  localparam int CNTW = $clog2(CONFIRM + 1);

  logic [CW-1:0]   period_reg;
  logic            strobe_d1_reg;
  logic            strobe_d2_reg;
  logic [15:0]     sample;
  obst_state_t     state_reg, state_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic [CNTW-1:0] cnt_inc;
  logic            eval, near, far;

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      period_reg    <= '0;
      strobe_d1_reg <= 1'b0;
      strobe_d2_reg <= 1'b0;
    end else begin
      period_reg    <= sample_strobe ? '0 : period_reg + 1'b1;
      strobe_d1_reg <= sample_strobe;
      strobe_d2_reg <= strobe_d1_reg;
    end
  end

  assign sample_strobe = (period_reg == CW'(SAMPLE_PERIOD - 1));
  // A zero reading means the front end timed out without an echo.
  assign sample = (distance_in == 16'd0) ? 16'(NO_ECHO_MM) : distance_in;

  us_moving_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk_50M      (clk_50M),
    .reset        (reset),
    .sample       (sample),
    .sample_strobe(sample_strobe),
    .distance_avg (distance_avg),
    .avg_valid    (avg_valid)
  );

  // The average for the strobed sample is visible two cycles later.
  assign eval    = strobe_d2_reg && avg_valid;
  assign near    = (distance_avg < 16'(NEAR_MM));
  assign far     = (distance_avg >= 16'(FAR_MM));
  assign cnt_inc = cnt_reg + 1'b1;

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_reg <= FILL;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (eval) begin
      case (state_reg)
        FILL, CLEAR: begin
          state_next = CLEAR;
          if (!near) begin
            cnt_next = '0;
          end else if (cnt_inc == CNTW'(CONFIRM)) begin
            state_next = SET;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        SET: begin
          if (!far) begin
            cnt_next = '0;
          end else if (cnt_inc == CNTW'(CONFIRM)) begin
            state_next = CLEAR;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = FILL;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    obstacle = (state_reg == SET);
  end

endmodule

// File: tb/tb_us_distance_filter.sv
// Directed self-checking bench for us_distance_filter with a shortened sample period.
module tb_us_distance_filter;

  localparam int P = 1100;

  logic        clk_50M;
  logic        reset;
  logic [15:0] distance_in;
  logic        sample_strobe;
  logic [15:0] distance_avg;
  logic        avg_valid;
  logic        obstacle;

  int n_vec = 0;
  int n_err = 0;
  int gap;
  logic [15:0] avg_t2;
  logic        valid_t2;
  logic        obst_t2;

  us_distance_filter #(
    .SAMPLE_PERIOD(P)
  ) dut (
    .clk_50M      (clk_50M),
    .reset        (reset),
    .distance_in  (distance_in),
    .sample_strobe(sample_strobe),
    .distance_avg (distance_avg),
    .avg_valid    (avg_valid),
    .obstacle     (obstacle)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0d expected=%0d", n_vec, tag, obs, exp);
  endtask

  // Present d, wait for its strobe (cycle T), record outputs at T+2, return at T+3.
  task automatic feed(input logic [15:0] d);
    int k;
    distance_in = d;
    k = 0;
    while (!sample_strobe && k < P + 5) begin
      @(negedge clk_50M);
      k++;
    end
    gap = k;
    if (!sample_strobe) chk("strobe_timeout", 32'(k), 32'(P));
    @(negedge clk_50M);
    @(negedge clk_50M);
    avg_t2   = distance_avg;
    valid_t2 = avg_valid;
    obst_t2  = obstacle;
    @(negedge clk_50M);
  endtask

  initial begin
    reset       = 1'b1;
    distance_in = 16'd200;
    repeat (3) @(negedge clk_50M);
    chk("rst_strobe", 32'(sample_strobe), 32'd0);
    chk("rst_avg", 32'(distance_avg), 32'd0);
    chk("rst_valid", 32'(avg_valid), 32'd0);
    chk("rst_obst", 32'(obstacle), 32'd0);
    reset = 1'b0;

    // Fill the window at 200 mm.
    feed(16'd200);
    chk("first_strobe_wait", 32'(gap), 32'(P - 1));
    feed(16'd200);
    chk("strobe_period", 32'(gap + 3), 32'(P));
    feed(16'd200);
    chk("valid_3rd", 32'(valid_t2), 32'd0);
    chk("avg_before_valid", 32'(avg_t2), 32'd150);
    feed(16'd200);
    chk("valid_4th", 32'(valid_t2), 32'd1);
    chk("avg_200", 32'(avg_t2), 32'd200);
    chk("obst_200", 32'(obstacle), 32'd0);

    // Approach: 160,120,80 then three sub-70 averages set the flag.
    feed(16'd40); chk("avg_160", 32'(avg_t2), 32'd160);
    feed(16'd40); chk("avg_120", 32'(avg_t2), 32'd120);
    feed(16'd40); chk("avg_80", 32'(avg_t2), 32'd80);
    feed(16'd40); chk("avg_40", 32'(avg_t2), 32'd40);
    feed(16'd40); chk("obst_after_2near", 32'(obstacle), 32'd0);
    feed(16'd40);
    chk("obst_t2_3near", 32'(obst_t2), 32'd0);
    chk("obst_t3_3near", 32'(obstacle), 32'd1);

    // In-band oscillation must not clear the flag.
    for (int i = 0; i < 10; i++) begin
      feed((i % 2 == 0) ? 16'd75 : 16'd85);
      chk("obst_inband", 32'(obstacle), 32'd1);
    end
    chk("avg_inband", 32'(avg_t2), 32'd80);

    // Recede: 86 (in-band), then 90, 96, 100 far -> clears on the third.
    feed(16'd100); chk("avg_86", 32'(avg_t2), 32'd86);
    feed(16'd100); chk("avg_90", 32'(avg_t2), 32'd90);
    feed(16'd100); chk("obst_2far", 32'(obstacle), 32'd1);
    feed(16'd100);
    chk("avg_100", 32'(avg_t2), 32'd100);
    chk("obst_t2_3far", 32'(obst_t2), 32'd1);
    chk("obst_t3_3far", 32'(obstacle), 32'd0);

    // Glitch between strobes must not disturb anything.
    distance_in = 16'd10;
    repeat (1000) @(negedge clk_50M);
    chk("glitch_avg", 32'(distance_avg), 32'd100);
    chk("glitch_valid", 32'(avg_valid), 32'd1);
    chk("glitch_obst", 32'(obstacle), 32'd0);
    feed(16'd100);
    chk("glitch_next_avg", 32'(avg_t2), 32'd100);

    // No echo reads as 4000 mm.
    feed(16'd0); chk("avg_noecho1", 32'(avg_t2), 32'd1075);
    feed(16'd0);
    feed(16'd0);
    feed(16'd0);
    chk("avg_noecho4", 32'(avg_t2), 32'd4000);
    chk("obst_noecho", 32'(obstacle), 32'd0);

    feed(16'd60);
    feed(16'd60);
    feed(16'd0);
    feed(16'd0);
    chk("avg_mix", 32'(avg_t2), 32'd2030);

    // Drive the flag high again before the mid-window reset.
    feed(16'd40); chk("avg_2025", 32'(avg_t2), 32'd2025);
    feed(16'd40); chk("avg_2020", 32'(avg_t2), 32'd2020);
    feed(16'd40); chk("avg_1030", 32'(avg_t2), 32'd1030);
    feed(16'd40);
    feed(16'd40);
    feed(16'd40);
    chk("obst_reset_pre", 32'(obstacle), 32'd1);

    repeat (100) @(negedge clk_50M);
    reset = 1'b1;
    #1;
    chk("async_obst", 32'(obstacle), 32'd0);
    chk("async_valid", 32'(avg_valid), 32'd0);
    chk("async_avg", 32'(distance_avg), 32'd0);
    @(negedge clk_50M);
    reset = 1'b0;

    feed(16'd200);
    feed(16'd200);
    feed(16'd200);
    chk("post_rst_valid3", 32'(valid_t2), 32'd0);
    feed(16'd200);
    chk("post_rst_valid4", 32'(valid_t2), 32'd1);
    chk("post_rst_avg", 32'(avg_t2), 32'd200);
    chk("post_rst_obst", 32'(obstacle), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
